// File: rtl/mem_wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_pkg
// Shared pipeline definitions for the MEM/WB stage: EX/MEM control-bit
// layout, the data-memory FSM state encoding and the wait-counter width.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_wb_stage_pkg;

   // EX/MEM control bits as carried down the pipeline
   typedef struct packed {
      logic regwrite;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
   } exmem_ctrl_t;

   // Data-memory handshake FSM
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_t;

   // Wait counter width; covers TIMEOUT_CYCLES up to 255
   localparam int unsigned CNT_W = 8;
   typedef logic [CNT_W-1:0] cnt_t;

   function automatic logic is_word_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/mem_wb_stage_timeout_counter.sv
// -----------------------------------------------------------------------------
// dmem_timeout_counter
// Counts cycles a data-memory request has been waiting for its ack.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (count -> 0)
//   i_load        load count with 1 (request issued, not acked)
//   i_inc         increment count (still waiting)
//   i_clear       return count to 0 (request finished)
//   o_terminal    count == TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module dmem_timeout_counter
   import mem_wb_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_inc,
   input  logic i_clear,
   output logic o_terminal
);

   cnt_t r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= cnt_t'(1);
      end else if (i_inc) begin
         r_count <= r_count + cnt_t'(1);
      end else if (i_clear) begin
         r_count <= '0;
      end
   end

   assign o_terminal = (r_count == cnt_t'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// MEM stage data-memory handshake plus the MEM/WB pipeline register.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   mem_alu_result, mem_write_data EX/MEM address/ALU result and store data
//   mem_rd, mem_regwrite,
//   mem_mem_read, mem_mem_write,
//   mem_mem_to_reg                 EX/MEM destination and control bits
//   dmem_req/we/addr/wdata         data-memory request (out)
//   dmem_rdata, dmem_ack           data-memory response (in)
//   mem_stall                      hold EX/MEM and earlier stages
//   wb_rd, wb_regwrite, wb_data    MEM/WB register
//   mem_misalign, mem_bus_err      single-cycle error pulses
// -----------------------------------------------------------------------------
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_alu_result,
   input  logic [31:0] mem_write_data,
   input  logic [4:0]  mem_rd,
   input  logic        mem_regwrite,
   input  logic        mem_mem_read,
   input  logic        mem_mem_write,
   input  logic        mem_mem_to_reg,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        mem_stall,
   output logic [4:0]  wb_rd,
   output logic        wb_regwrite,
   output logic [31:0] wb_data,
   output logic        mem_misalign,
   output logic        mem_bus_err
);

   mem_state_t  r_state;
   logic [4:0]  r_wb_rd;
   logic        r_wb_regwrite;
   logic [31:0] r_wb_data;

   exmem_ctrl_t w_ctrl;
   logic        w_mem_op;
   logic        w_aligned;
   logic        w_active;
   logic        w_terminal;
   logic        w_abort;
   logic        w_misalign;
   logic        w_stall;
   logic        w_cnt_load;
   logic        w_cnt_inc;
   logic        w_cnt_clear;
   logic [31:0] w_wb_data;
   logic        w_wb_regwrite;

   always_comb begin
      w_ctrl     = '{regwrite:   mem_regwrite,
                     mem_read:   mem_mem_read,
                     mem_write:  mem_mem_write,
                     mem_to_reg: mem_mem_to_reg};
      w_mem_op   = w_ctrl.mem_read | w_ctrl.mem_write;
      w_aligned  = is_word_aligned(mem_alu_result);

      // Request is combinational from IDLE; rst gates it so an in-flight op
      // disappears from the bus the moment reset asserts.
      w_active   = !rst && ((r_state == ST_IDLE && w_mem_op && w_aligned) ||
                            (r_state == ST_WAIT));
      // Ack beats timeout in the terminal cycle.
      w_abort    = w_active && (r_state == ST_WAIT) && w_terminal && !dmem_ack;
      w_misalign = !rst && (r_state == ST_IDLE) && w_mem_op && !w_aligned;
      w_stall    = w_active && !dmem_ack && !w_abort;

      w_cnt_load  = (r_state == ST_IDLE) && w_stall;
      w_cnt_inc   = (r_state == ST_WAIT) && w_stall;
      w_cnt_clear = (r_state == ST_WAIT) && !w_stall;

      w_wb_data     = w_ctrl.mem_to_reg ? dmem_rdata : mem_alu_result;
      w_wb_regwrite = w_ctrl.regwrite && (mem_rd != 5'd0) && !w_ctrl.mem_write &&
                      !w_abort && !w_misalign;
   end

   dmem_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_cnt_load),
      .i_inc      (w_cnt_inc),
      .i_clear    (w_cnt_clear),
      .o_terminal (w_terminal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (w_stall)  r_state <= ST_WAIT;
            ST_WAIT: if (!w_stall) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // MEM/WB register: a stalled edge inserts a bubble but keeps rd/data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_rd       <= '0;
         r_wb_regwrite <= 1'b0;
         r_wb_data     <= '0;
      end else if (w_stall) begin
         r_wb_regwrite <= 1'b0;
      end else begin
         r_wb_rd       <= mem_rd;
         r_wb_regwrite <= w_wb_regwrite;
         r_wb_data     <= w_wb_data;
      end
   end

   assign dmem_req     = w_active;
   assign dmem_we      = w_ctrl.mem_write;
   assign dmem_addr    = {mem_alu_result[31:2], 2'b00};
   assign dmem_wdata   = mem_write_data;
   assign mem_stall    = w_stall;
   assign mem_misalign = w_misalign;
   assign mem_bus_err  = w_abort;
   assign wb_rd        = r_wb_rd;
   assign wb_regwrite  = r_wb_regwrite;
   assign wb_data      = r_wb_data;

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, meaning: maximum cycles a data-memory request waits for dmem_ack before abort (legal range 2..255).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mem_alu_result  input  32  EX/MEM ALU result; memory byte address for loads/stores.
REQ-005 mem_write_data  input  32  EX/MEM store data.
REQ-006 mem_rd  input  5  EX/MEM destination register.
REQ-007 mem_regwrite, mem_mem_read, mem_mem_write, mem_mem_to_reg  input  1 each  EX/MEM control bits.
REQ-008 dmem_req  output  1  data-memory request, held high until ack or abort.
REQ-009 dmem_we  output  1  1 = store, 0 = load; valid while dmem_req is high.
REQ-010 dmem_addr  output  32  word-aligned request address; dmem_wdata  output  32  store data.
REQ-011 dmem_rdata  input  32  load data, valid when dmem_ack is high; dmem_ack  input  1  request completion.
REQ-012 mem_stall  output  1  upstream must hold the EX/MEM contents and freeze earlier stages while high.
REQ-013 wb_rd  output  5; wb_regwrite  output  1; wb_data  output  32  MEM/WB register, which drives register-file write and forwarding.
REQ-014 mem_misalign  output  1; mem_bus_err  output  1  single-cycle error pulses.

Function
REQ-015 A memory op SHALL be defined as mem_mem_read or mem_mem_write; when both are high, the op SHALL be treated as a store.
REQ-016 The FSM SHALL have exactly two states, IDLE and WAIT.
REQ-017 In IDLE with an aligned memory op (mem_alu_result[1:0]==0), dmem_req SHALL be asserted combinationally in the same cycle, with dmem_addr = mem_alu_result and dmem_wdata = mem_write_data.
REQ-018 Zero-wait ack: if dmem_ack is high in that IDLE cycle, the op SHALL complete at that edge, mem_stall SHALL stay low, and the state SHALL remain IDLE.
REQ-019 If dmem_ack is low in that IDLE cycle, mem_stall SHALL be high, the state SHALL go to WAIT, and the wait counter SHALL load 1.
REQ-020 In WAIT, dmem_req SHALL stay high and mem_stall SHALL equal !dmem_ack; on dmem_ack the op SHALL complete and the state SHALL go to IDLE.
REQ-021 Without an ack in WAIT, the counter SHALL increment each cycle.
REQ-022 Timeout: in the WAIT cycle where counter == TIMEOUT_CYCLES-1 and no ack arrives, the op SHALL abort: mem_bus_err pulses that cycle, mem_stall is low, dmem_req drops next cycle, and the state goes to IDLE.
REQ-023 An abort SHALL capture a MEM/WB bubble (wb_regwrite=0).
REQ-024 Misaligned memory op: no dmem_req, mem_misalign pulses that cycle, no stall, and the op SHALL capture a bubble.
REQ-025 Non-memory ops SHALL pass through in 1 cycle with no request and no stall.
REQ-026 MEM/WB register update: every edge with mem_stall low SHALL capture wb_rd = mem_rd, wb_data = mem_mem_to_reg ? dmem_rdata : mem_alu_result, and wb_regwrite = mem_regwrite & (mem_rd != 0) & !abort & !misalign.
REQ-027 Every edge with mem_stall high SHALL capture a bubble: wb_regwrite = 0, with wb_rd and wb_data unchanged.
REQ-028 A store SHALL never set wb_regwrite, regardless of mem_regwrite.
REQ-029 The op-to-wb latency SHALL be 1 cycle after completion.
REQ-030 An ack arriving while dmem_req is low SHALL be ignored.
REQ-031 An ack arriving in the same cycle as the timeout condition SHALL win: normal completion, no error pulse.

Reset
REQ-032 rst SHALL force state IDLE and counter 0, and SHALL force wb_rd=0, wb_regwrite=0, wb_data=0.
REQ-033 Under rst, dmem_req, mem_stall, mem_misalign and mem_bus_err SHALL read 0 regardless of inputs.
REQ-034 rst asserted mid-WAIT SHALL drop dmem_req immediately; the in-flight op SHALL be discarded, and a late ack after reset release SHALL be ignored per REQ-030.

Structure
REQ-035 The state encoding (IDLE, WAIT) and the counter width (8 bits) SHALL live in the shared pipeline package, next to the existing control-bit definitions.
REQ-036 One sub-module, dmem_timeout_counter (load, increment, terminal-count compare), is natural; the FSM, the write-back mux and the MEM/WB register SHALL stay in mem_wb_stage.

Verification
REQ-037 ALU op (regwrite=1, rd=5, alu_result=0x1234, to_reg=0) -> next cycle wb_rd=5, wb_data=0x1234, wb_regwrite=1; mem_stall never high.
REQ-038 Load at addr 0x40, ack in the same cycle with rdata=0xDEADBEEF, rd=7 -> no stall, dmem_we=0; next cycle wb_data=0xDEADBEEF, wb_regwrite=1.
REQ-039 Store at 0x80, data 0xA5A5A5A5, ack 3 cycles late -> dmem_req high for 4 cycles, mem_stall high for 3, dmem_we=1, dmem_wdata=0xA5A5A5A5; wb_regwrite=0 throughout.
REQ-040 Load at 0x42 -> mem_misalign pulses 1 cycle, no dmem_req, wb_regwrite=0 next cycle.
REQ-041 TIMEOUT_CYCLES=4, load with no ack -> mem_stall high 3 cycles, mem_bus_err pulses on the 4th, then IDLE; repeat with ack on the 4th cycle -> no error, normal write-back.
REQ-042 rst pulse in the 2nd WAIT cycle, then ack 1 cycle after release -> dmem_req low from rst onward, ack ignored, all wb outputs 0.
